ifq_fetch_ctrl: RTL

Instruction fetch queue controller that sequences reads of the combinational instruction cache (i_cache) and buffers returned cache lines in a small FIFO. It delivers one 32-bit instruction per cycle, with its PC, to the dispatch stage. On a branch/jump redirect it flushes the queue, asserts abort to the cache and restarts fetch at the target. It sits between i_cache and dispatch in the IFQ RISC front end.

---
 rtl/ifq_pkg.sv | 12 +
 rtl/ifq_line_fifo.sv | 44 ++++
 rtl/ifq_fetch_ctrl.sv | 59 +++++
 3 files changed

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared widths, reset PC and FIFO entry type for the fetch queue
package ifq_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int CACHE_LINE_WIDTH = 128;
  localparam int WORDS_PER_LINE = CACHE_LINE_WIDTH / DATA_WIDTH;
  localparam int WORD_IDX_W = $clog2(WORDS_PER_LINE);
  localparam logic [DATA_WIDTH-1:0] RESET_PC = 32'h0040_0000;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [CACHE_LINE_WIDTH-1:0] line;
  } ifq_entry_t;
endpackage

// File: rtl/ifq_line_fifo.sv
// ifq_line_fifo: DEPTH-entry line FIFO with flush, full and empty flags
module ifq_line_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       wr_en,
  input  ifq_entry_t wr_data,
  input  logic       rd_en,
  output ifq_entry_t rd_data,
  output logic       full,
  output logic       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  ifq_entry_t mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign rd_data = mem_q[rd_ptr_q];
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(wr_en);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(rd_en);
    count_d = flush ? '0 : count_q + CW'(wr_en) - CW'(rd_en);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/ifq_fetch_ctrl.sv
// ifq_fetch_ctrl: sequences i_cache line fetches and streams one instruction per cycle to dispatch
module ifq_fetch_ctrl
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [DATA_WIDTH-1:0]       cache_pc,
  output logic                        cache_rd_en,
  output logic                        cache_abort,
  input  logic [CACHE_LINE_WIDTH-1:0] cache_line,
  input  logic                        cache_valid,
  input  logic                        redirect_valid,
  input  logic [DATA_WIDTH-1:0]       redirect_pc,
  input  logic                        disp_rd_en,
  output logic [DATA_WIDTH-1:0]       inst_out,
  output logic [DATA_WIDTH-1:0]       pc_out,
  output logic                        empty
);
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_IDX_W-1:0] word_idx_q, word_idx_d;
  logic full, wr_en, pop, line_free;
  ifq_entry_t head;
  ifq_line_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirect_valid),
    .wr_en  (wr_en),
    .wr_data({fetch_pc_q, cache_line}),
    .rd_en  (line_free),
    .rd_data(head),
    .full   (full),
    .empty  (empty)
  );
  assign cache_pc = fetch_pc_q;
  assign cache_rd_en = !full && !redirect_valid;
  assign cache_abort = redirect_valid && !rst;
  assign wr_en = cache_rd_en && cache_valid;
  assign pop = disp_rd_en && !empty && !redirect_valid;
  assign line_free = pop && word_idx_q == WORD_IDX_W'(WORDS_PER_LINE - 1);
  assign inst_out = empty ? '0 : DATA_WIDTH'(head.line >> (word_idx_q * DATA_WIDTH));
  assign pc_out = empty ? '0 : head.pc + DATA_WIDTH'({word_idx_q, 2'b00});
  always_comb begin
    fetch_pc_d = redirect_valid ? {redirect_pc[DATA_WIDTH-1:4], 4'b0} :
                 wr_en ? fetch_pc_q + DATA_WIDTH'(16) : fetch_pc_q;
    word_idx_d = redirect_valid ? redirect_pc[WORD_IDX_W+1:2] :
                 pop ? word_idx_q + 1'b1 : word_idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      word_idx_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      word_idx_q <= word_idx_d;
    end
  end
endmodule
